wb_switch_pipe: RTL and testbench
=================================

WB_SWITCH_PIPE -- requirements
Module: wb_switch_pipe

Interface
REQ-001 The block SHALL have parameter NSLAVES, default 9, meaning slave port count (2..16); the last index is the default slave.
REQ-002 The block SHALL have parameter AW, default 20, meaning word-address width (address bits [AW:1]).
REQ-003 The block SHALL have parameter DW, default 16, meaning data width (multiple of 8); select width SW = DW/8.
REQ-004 The block SHALL have parameter SLV_ADDR, default all zero, meaning packed NSLAVES*AW match addresses, slave i at bits [i*AW +: AW].
REQ-005 The block SHALL have parameter SLV_MASK, default all zero, meaning packed NSLAVES*AW masks, same layout as SLV_ADDR.
REQ-006 The block SHALL have parameter TIMEOUT, default 255, meaning maximum wait cycles for a slave ack (1..65535).
REQ-007 The block SHALL have the ports: wb_clk_i in 1 clock; wb_rst_i in 1 synchronous active-high reset.
REQ-008 The block SHALL have the ports: m_dat_i in DW; m_dat_o out DW; m_adr_i in [AW:1]; m_sel_i in SW; m_we_i in 1; m_cyc_i in 1; m_stb_i in 1; m_ack_o out 1.
REQ-009 The block SHALL have the ports: s_dat_i in NSLAVES*DW; s_dat_o out DW; s_adr_o out [AW:1]; s_sel_o out SW; s_we_o out 1; s_cyc_o out NSLAVES; s_stb_o out NSLAVES; s_ack_i in NSLAVES.
REQ-010 The block SHALL have the port timeout_o out 1, a one-cycle pulse on timeout abort.

Function
REQ-011 Decode SHALL be priority-based: the lowest index i with (m_adr_i & SLV_MASK[i]) == SLV_ADDR[i], for i < NSLAVES-1, wins; if none matches, the default slave NSLAVES-1 is selected.
REQ-012 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-013 In IDLE with m_cyc_i & m_stb_i & ~m_ack_o, the block SHALL register the selected index, adr, sel, dat and we, and move to BUSY next cycle.
REQ-014 In BUSY, s_stb_o and s_cyc_o SHALL be high only for the registered index; all other bits SHALL be 0; s_adr_o, s_sel_o, s_dat_o and s_we_o SHALL be the registered values.
REQ-015 In BUSY, when s_ack_i of the selected slave is 1, the block SHALL capture that slave's s_dat_i into m_dat_o, drop s_stb_o and s_cyc_o next cycle, and enter RESP.
REQ-016 In RESP, m_ack_o SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE; m_dat_o SHALL hold its value until the next capture.
REQ-017 Latency SHALL be: master stb at cycle 0 gives slave stb at cycle 1; slave ack at cycle k gives m_ack_o at cycle k+1; minimum round trip is 2 cycles.
REQ-018 s_ack_i from non-selected slaves SHALL be ignored in every state.
REQ-019 If m_cyc_i falls in BUSY, the block SHALL drop s_stb_o and s_cyc_o next cycle, return to IDLE, and assert no m_ack_o; an ack arriving in that same cycle SHALL be discarded.
REQ-020 A new master request SHALL NOT be accepted in the cycle m_ack_o is 1.

Reset
REQ-021 On wb_rst_i sampled high, the FSM SHALL go to IDLE, and m_ack_o, s_stb_o, s_cyc_o, timeout_o, m_dat_o, s_dat_o, s_adr_o, s_sel_o, s_we_o and the wait counter SHALL all be 0.
REQ-022 Reset mid-transaction SHALL abort that transaction without asserting m_ack_o.

Configuration
REQ-023 With WB_SWITCH_TIMEOUT_EN defined, a 16-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack; when it reaches TIMEOUT, the block SHALL drop the slave strobes, load m_dat_o = all ones, pulse timeout_o, and go to RESP so that m_ack_o is 1 one cycle later.
REQ-024 Without WB_SWITCH_TIMEOUT_EN, the block SHALL have no counter, timeout_o SHALL be tied to 0, and BUSY SHALL wait indefinitely.

Structure
REQ-025 Package wb_switch_pkg SHALL hold the FSM state encoding (IDLE=0, BUSY=1, RESP=2) and the counter width constant (16).
REQ-026 The combinational priority address decoder SHALL be a sub-module, wb_addr_decode, parametrised by NSLAVES, AW, SLV_ADDR and SLV_MASK, outputting a one-hot select.

Verification
REQ-027 Bench SHALL check: NSLAVES=3, slave0 mask 20'hF0000 addr 20'hA0000, read 20'hA0010, slave0 acks at cycle 3 with 16'h1234 -> only s_stb_o[0] is high in cycles 1..3, m_ack_o is high at cycle 4, and m_dat_o is 16'h1234.
REQ-028 Bench SHALL check: slaves 0 and 1 both matching 20'hB8000 -> only s_stb_o[0] is asserted (priority).
REQ-029 Bench SHALL check: write to unmapped 20'h12345 with data 16'hBEEF -> s_stb_o[2] (default slave) is asserted, s_dat_o is 16'hBEEF, and s_sel_o equals m_sel_i.
REQ-030 Bench SHALL check: spurious s_ack_i[1] while slave 0 is selected -> no m_ack_o; m_cyc_i dropped in BUSY -> IDLE and no ack.
REQ-031 Bench SHALL check: with WB_SWITCH_TIMEOUT_EN and TIMEOUT=4, a silent slave -> timeout_o pulses, then m_ack_o with m_dat_o = 16'hFFFF; without the macro, the block stays in BUSY for 100 cycles.
REQ-032 Bench SHALL check: wb_rst_i asserted in BUSY -> next cycle all outputs are 0 and the FSM is IDLE.

Source files
------------

// File: rtl/wb_switch_pkg.sv
// Shared types and constants for the Wishbone single-master switch.
package wb_switch_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_switch_pipe_addr_decode.sv
// Priority address decoder: the lowest-index mapped slave whose masked address
// matches wins; the last slave catches every unmatched address.
module wb_addr_decode #(
  parameter int unsigned           NSLAVES  = 9,
  parameter int unsigned           AW       = 20,
  parameter logic [NSLAVES*AW-1:0] SLV_ADDR = '0,
  parameter logic [NSLAVES*AW-1:0] SLV_MASK = '0
) (
  input  logic [AW:1]        adr_i,
  output logic [NSLAVES-1:0] sel_oh_c
);

  // Walk from the highest mapped index down so the lowest match overwrites last.
  always_comb begin
    sel_oh_c              = '0;
    sel_oh_c[NSLAVES-1]   = 1'b1;
    for (int i = int'(NSLAVES) - 2; i >= 0; i--) begin
      if ((adr_i & SLV_MASK[i*AW +: AW]) == SLV_ADDR[i*AW +: AW]) begin
        sel_oh_c    = '0;
        sel_oh_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_switch_pipe.sv
// Registered single-master to NSLAVES Wishbone switch with priority decode.
// Optional ack watchdog enabled by defining WB_SWITCH_TIMEOUT_EN.
module wb_switch_pipe
  import wb_switch_pkg::*;
#(
  parameter int unsigned           NSLAVES  = 9,
  parameter int unsigned           AW       = 20,
  parameter int unsigned           DW       = 16,
  parameter logic [NSLAVES*AW-1:0] SLV_ADDR = '0,
  parameter logic [NSLAVES*AW-1:0] SLV_MASK = '0,
  parameter int unsigned           TIMEOUT  = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [DW-1:0]         m_dat_i,
  output logic [DW-1:0]         m_dat_o,
  input  logic [AW:1]           m_adr_i,
  input  logic [DW/8-1:0]       m_sel_i,
  input  logic                  m_we_i,
  input  logic                  m_cyc_i,
  input  logic                  m_stb_i,
  output logic                  m_ack_o,
  input  logic [NSLAVES*DW-1:0] s_dat_i,
  output logic [DW-1:0]         s_dat_o,
  output logic [AW:1]           s_adr_o,
  output logic [DW/8-1:0]       s_sel_o,
  output logic                  s_we_o,
  output logic [NSLAVES-1:0]    s_cyc_o,
  output logic [NSLAVES-1:0]    s_stb_o,
  input  logic [NSLAVES-1:0]    s_ack_i,
  output logic                  timeout_o
);

  localparam int unsigned SW = DW / 8;

  if ((NSLAVES < 2) || (NSLAVES > 16) || ((DW % 8) != 0) ||
      (TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_cfg
    $error("wb_switch_pipe: illegal parameter combination");
  end

  state_e               state_q, state_d;
  logic [NSLAVES-1:0]   s_stb_q, s_stb_d;
  logic [AW:1]          s_adr_q, s_adr_d;
  logic [SW-1:0]        s_sel_q, s_sel_d;
  logic [DW-1:0]        s_dat_q, s_dat_d;
  logic                 s_we_q,  s_we_d;
  logic [DW-1:0]        m_dat_q, m_dat_d;
  logic                 m_ack_q, m_ack_d;

  logic [NSLAVES-1:0]   sel_oh_c;
  logic                 ack_hit_c;
  logic [DW-1:0]        ack_dat_c;
  logic                 timeout_hit_c;

  wb_addr_decode #(
    .NSLAVES  (NSLAVES),
    .AW       (AW),
    .SLV_ADDR (SLV_ADDR),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .adr_i    (m_adr_i),
    .sel_oh_c (sel_oh_c)
  );

  // s_stb_q is only non-zero in BUSY, so it also masks acks from idle slaves.
  assign ack_hit_c = |(s_ack_i & s_stb_q);

  always_comb begin
    ack_dat_c = '0;
    for (int i = 0; i < int'(NSLAVES); i++) begin
      if (s_stb_q[i]) ack_dat_c = s_dat_i[i*DW +: DW];
    end
  end

`ifdef WB_SWITCH_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Counter sits at zero outside BUSY, so it is clear on every BUSY entry.
  always_comb begin
    cnt_d         = '0;
    timeout_hit_c = 1'b0;
    if (state_q == BUSY) begin
      cnt_d         = cnt_q + CNT_W'(1);
      timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));
    end
    timeout_d = timeout_hit_c & m_cyc_i & ~ack_hit_c;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_hit_c = 1'b0;
  assign timeout_o     = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    s_stb_d = s_stb_q;
    s_adr_d = s_adr_q;
    s_sel_d = s_sel_q;
    s_dat_d = s_dat_q;
    s_we_d  = s_we_q;
    m_dat_d = m_dat_q;
    m_ack_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i && !m_ack_q) begin
          state_d = BUSY;
          s_stb_d = sel_oh_c;
          s_adr_d = m_adr_i;
          s_sel_d = m_sel_i;
          s_dat_d = m_dat_i;
          s_we_d  = m_we_i;
        end
      end
      BUSY: begin
        if (!m_cyc_i) begin
          state_d = IDLE;
          s_stb_d = '0;
        end else if (ack_hit_c) begin
          state_d = RESP;
          s_stb_d = '0;
          m_dat_d = ack_dat_c;
          m_ack_d = 1'b1;
        end else if (timeout_hit_c) begin
          state_d = RESP;
          s_stb_d = '0;
          m_dat_d = '1;
        end
      end
      RESP: begin
        // Timeout entry arrives with m_ack_q low and acks one cycle later.
        if (m_ack_q) state_d = IDLE;
        else         m_ack_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        s_stb_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      s_stb_q <= '0;
      s_adr_q <= '0;
      s_sel_q <= '0;
      s_dat_q <= '0;
      s_we_q  <= 1'b0;
      m_dat_q <= '0;
      m_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_stb_q <= s_stb_d;
      s_adr_q <= s_adr_d;
      s_sel_q <= s_sel_d;
      s_dat_q <= s_dat_d;
      s_we_q  <= s_we_d;
      m_dat_q <= m_dat_d;
      m_ack_q <= m_ack_d;
    end
  end

  assign s_stb_o = s_stb_q;
  assign s_cyc_o = s_stb_q;
  assign s_adr_o = s_adr_q;
  assign s_sel_o = s_sel_q;
  assign s_dat_o = s_dat_q;
  assign s_we_o  = s_we_q;
  assign m_dat_o = m_dat_q;
  assign m_ack_o = m_ack_q;

endmodule

// File: tb/tb_wb_switch_pipe.sv
// Randomized self-checking bench for wb_switch_pipe against a transaction-level model.
`timescale 1ns/1ps
module tb_wb_switch_pipe;

  localparam int unsigned NS  = 3;
  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 16;
  localparam int unsigned SW  = 2;
  localparam int unsigned TMO = 4;

  localparam logic [NS*AW-1:0] MAP_ADDR = {20'h00000, 20'h50000, 20'hA0000};
  localparam logic [NS*AW-1:0] MAP_MASK = {20'h00000, 20'hF0000, 20'hF0000};
  localparam logic [NS*AW-1:0] PRI_ADDR = {20'h00000, 20'hB8000, 20'hB0000};
  localparam logic [NS*AW-1:0] PRI_MASK = {20'h00000, 20'hF8000, 20'hF0000};

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    m_dat_i, m_dat_o, s_dat_o;
  logic [AW:1]      m_adr_i, s_adr_o;
  logic [SW-1:0]    m_sel_i, s_sel_o;
  logic             m_we_i, m_cyc_i, m_stb_i, m_ack_o, s_we_o, timeout_o;
  logic [NS*DW-1:0] s_dat_i;
  logic [NS-1:0]    s_cyc_o, s_stb_o, s_ack_i;

  logic [DW-1:0]    p_m_dat_o, p_s_dat_o;
  logic [AW:1]      p_s_adr_o;
  logic [SW-1:0]    p_s_sel_o;
  logic             p_m_ack_o, p_s_we_o, p_timeout_o;
  logic [NS*DW-1:0] p_s_dat_i = '0;
  logic [NS-1:0]    p_s_cyc_o, p_s_stb_o;
  logic [NS-1:0]    p_s_ack_i = '0;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [DW-1:0]    last_rd;

  // Address map of the main instance as plain region tables.
  logic [19:0] region_base [2] = '{20'hA0000, 20'h50000};
  logic [19:0] region_mask [2] = '{20'hF0000, 20'hF0000};

  always #5 clk = ~clk;

  wb_switch_pipe #(
    .NSLAVES (NS), .AW (AW), .DW (DW),
    .SLV_ADDR (MAP_ADDR), .SLV_MASK (MAP_MASK), .TIMEOUT (TMO)
  ) u_dut (
    .wb_clk_i (clk),      .wb_rst_i (rst),
    .m_dat_i  (m_dat_i),  .m_dat_o  (m_dat_o),
    .m_adr_i  (m_adr_i),  .m_sel_i  (m_sel_i),
    .m_we_i   (m_we_i),   .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),  .m_ack_o  (m_ack_o),
    .s_dat_i  (s_dat_i),  .s_dat_o  (s_dat_o),
    .s_adr_o  (s_adr_o),  .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),   .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),  .s_ack_i  (s_ack_i),
    .timeout_o(timeout_o)
  );

  wb_switch_pipe #(
    .NSLAVES (NS), .AW (AW), .DW (DW),
    .SLV_ADDR (PRI_ADDR), .SLV_MASK (PRI_MASK), .TIMEOUT (TMO)
  ) u_pri (
    .wb_clk_i (clk),        .wb_rst_i (rst),
    .m_dat_i  (m_dat_i),    .m_dat_o  (p_m_dat_o),
    .m_adr_i  (m_adr_i),    .m_sel_i  (m_sel_i),
    .m_we_i   (m_we_i),     .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),    .m_ack_o  (p_m_ack_o),
    .s_dat_i  (p_s_dat_i),  .s_dat_o  (p_s_dat_o),
    .s_adr_o  (p_s_adr_o),  .s_sel_o  (p_s_sel_o),
    .s_we_o   (p_s_we_o),   .s_cyc_o  (p_s_cyc_o),
    .s_stb_o  (p_s_stb_o),  .s_ack_i  (p_s_ack_i),
    .timeout_o(p_timeout_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_slave(input logic [19:0] a);
    for (int i = 0; i < 2; i++)
      if ((a & region_mask[i]) == region_base[i]) return i;
    return 2;
  endfunction

  task automatic master_idle();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
  endtask

  task automatic master_req(input logic [19:0] a, input logic we, input logic [1:0] sel,
                            input logic [15:0] wd);
    m_adr_i = a; m_we_i = we; m_sel_i = sel; m_dat_i = wd;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
  endtask

  // Request at cycle 0, slave stb cycles 1..k, slave ack at k, master ack at k+1.
  task automatic do_txn(input logic [19:0] a, input logic we, input logic [1:0] sel,
                        input logic [15:0] wd, input int k, input logic [15:0] rd,
                        input bit spur);
    int          s;
    logic [2:0]  oh;
    s     = exp_slave(a);
    oh    = '0;
    oh[s] = 1'b1;
    master_req(a, we, sel, wd);
    tick();
    for (int c = 1; c <= k; c++) begin
      check_eq("slv_stb", 64'(s_stb_o), 64'(oh));
      check_eq("slv_cyc", 64'(s_cyc_o), 64'(oh));
      check_eq("m_ack_wait", 64'(m_ack_o), 64'd0);
      if (c == 1) begin
        check_eq("s_adr", 64'(s_adr_o), 64'(a));
        check_eq("s_sel", 64'(s_sel_o), 64'(sel));
        check_eq("s_we", 64'(s_we_o), 64'(we));
        check_eq("s_dat", 64'(s_dat_o), 64'(wd));
        check_eq("m_dat_hold", 64'(m_dat_o), 64'(last_rd));
      end
      s_dat_i = 48'({$urandom(), $urandom()});
      s_ack_i = '0;
      if (spur) s_ack_i = 3'($urandom()) & ~oh;
      if (c == k) begin
        s_ack_i = s_ack_i | oh;
        s_dat_i[s*DW +: DW] = rd;
      end
      tick();
      s_ack_i = '0;
    end
    check_eq("m_ack", 64'(m_ack_o), 64'd1);
    check_eq("m_dat", 64'(m_dat_o), 64'(rd));
    check_eq("slv_stb_drop", 64'(s_stb_o), 64'd0);
    check_eq("timeout_quiet", 64'(timeout_o), 64'd0);
    master_idle();
    tick();
    check_eq("m_ack_single", 64'(m_ack_o), 64'd0);
    check_eq("slv_stb_idle", 64'(s_stb_o), 64'd0);
    last_rd = rd;
  endtask

  task automatic check_all_zero();
    check_eq("rst_m_ack", 64'(m_ack_o), 64'd0);
    check_eq("rst_s_stb", 64'(s_stb_o), 64'd0);
    check_eq("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    check_eq("rst_timeout", 64'(timeout_o), 64'd0);
    check_eq("rst_m_dat", 64'(m_dat_o), 64'd0);
    check_eq("rst_s_dat", 64'(s_dat_o), 64'd0);
    check_eq("rst_s_adr", 64'(s_adr_o), 64'd0);
    check_eq("rst_s_sel", 64'(s_sel_o), 64'd0);
    check_eq("rst_s_we", 64'(s_we_o), 64'd0);
    check_eq("rst_state", 64'(u_dut.state_q), 64'd0);
`ifdef WB_SWITCH_TIMEOUT_EN
    check_eq("rst_cnt", 64'(u_dut.cnt_q), 64'd0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] a;
    int          r;
    int          kmax;

    rst = 1'b1; s_ack_i = '0; s_dat_i = '0;
    m_adr_i = '0; m_sel_i = '0; m_dat_i = '0; m_we_i = 1'b0;
    master_idle();
    tick(); tick();
    check_all_zero();
    rst = 1'b0;
    last_rd = '0;
    tick();

    // Read at A0010, slave 0 acks at cycle 3.
    do_txn(20'hA0010, 1'b0, 2'b11, 16'h0000, 3, 16'h1234, 1'b0);

    // Unmapped write lands on the default slave; minimum round trip.
    do_txn(20'h12345, 1'b1, 2'b10, 16'hBEEF, 1, 16'h5A5A, 1'b0);

    // Overlapping regions: lowest index takes the access.
    tick(); tick(); tick();
    master_req(20'hB8000, 1'b0, 2'b11, 16'h0000);
    tick();
    check_eq("pri_stb", 64'(p_s_stb_o), 64'b001);
    check_eq("pri_main_default", 64'(s_stb_o), 64'b100);
    master_idle();
    tick();
    check_eq("pri_drop", 64'(p_s_stb_o), 64'd0);

    // Spurious ack from slave 1, then master abort with a same-cycle ack.
    master_req(20'hA0400, 1'b0, 2'b01, 16'h0000);
    tick();
    s_ack_i = 3'b010;
    s_dat_i = 48'h1111_2222_3333;
    tick();
    s_ack_i = '0;
    check_eq("spur_no_ack", 64'(m_ack_o), 64'd0);
    check_eq("spur_stb_held", 64'(s_stb_o), 64'b001);
    tick();
    check_eq("spur_no_ack2", 64'(m_ack_o), 64'd0);
    master_idle();
    s_ack_i = 3'b001;
    tick();
    s_ack_i = '0;
    check_eq("abort_stb", 64'(s_stb_o), 64'd0);
    check_eq("abort_no_ack", 64'(m_ack_o), 64'd0);
    check_eq("abort_dat_kept", 64'(m_dat_o), 64'(last_rd));
    check_eq("abort_idle", 64'(u_dut.state_q), 64'd0);
    tick();
    check_eq("abort_no_ack2", 64'(m_ack_o), 64'd0);

    // Silent slave.
    master_req(20'h50020, 1'b0, 2'b11, 16'h0000);
    tick();
`ifdef WB_SWITCH_TIMEOUT_EN
    for (int c = 1; c <= int'(TMO); c++) begin
      check_eq("to_wait_stb", 64'(s_stb_o), 64'b010);
      check_eq("to_wait_pulse", 64'(timeout_o), 64'd0);
      tick();
    end
    check_eq("to_pulse", 64'(timeout_o), 64'd1);
    check_eq("to_stb_drop", 64'(s_stb_o), 64'd0);
    check_eq("to_no_ack_yet", 64'(m_ack_o), 64'd0);
    tick();
    check_eq("to_ack", 64'(m_ack_o), 64'd1);
    check_eq("to_dat", 64'(m_dat_o), 64'hFFFF);
    check_eq("to_pulse_single", 64'(timeout_o), 64'd0);
    master_idle();
    tick();
    check_eq("to_ack_single", 64'(m_ack_o), 64'd0);
    last_rd = 16'hFFFF;
    kmax = int'(TMO);
`else
    for (int c = 1; c <= 100; c++) begin
      check_eq("hang_stb", 64'(s_stb_o), 64'b010);
      check_eq("hang_no_ack", 64'(m_ack_o), 64'd0);
      check_eq("hang_no_timeout", 64'(timeout_o), 64'd0);
      tick();
    end
    master_idle();
    tick();
    check_eq("hang_abort", 64'(s_stb_o), 64'd0);
    kmax = 6;
`endif

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 2));
      a = 20'($urandom());
      if (r == 0) a[19:16] = 4'hA;
      else if (r == 1) a[19:16] = 4'h5;
      do_txn(a, 1'($urandom()), 2'($urandom()), 16'($urandom()),
             int'($urandom_range(1, kmax)), 16'($urandom()), 1'($urandom()));
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Reset while BUSY.
    master_req(20'hA0008, 1'b1, 2'b11, 16'hC0DE);
    tick();
    check_eq("pre_rst_busy", 64'(s_stb_o), 64'b001);
    rst = 1'b1;
    tick();
    check_all_zero();
    rst = 1'b0;
    master_idle();
    tick();
    check_eq("post_rst_no_ack", 64'(m_ack_o), 64'd0);
    last_rd = '0;

    do_txn(20'h5FFFE, 1'b0, 2'b11, 16'h0000, 2, 16'h0F0F, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
